layer_input_loader: RTL and testbench

- Producer side of the neuron interface: receives a serial 16-bit pixel/activation stream with a valid/ready handshake.
- Assembles the stream into the parallel input_vector consumed by a layer of neuron instances, then pulses start.
- Collects each neuron's done and signals frame completion before accepting the next frame.
- Sits between the input source (or the previous layer's serializer) and one layer of neurons.

---
 rtl/dnn_pkg.sv | 15 +
 rtl/done_tracker.sv | 39 +++
 rtl/layer_input_loader.sv | 112 +++++++++++
 tb/tb_layer_input_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared types for the layer datapath: stream element width and loader FSM states.
package dnn_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    LOAD,
    FIRE,
    WAIT,
    DRAIN
  } loader_state_t;

endpackage

// File: rtl/done_tracker.sv
// Sticky per-neuron done collection with same-cycle completion detect and a WAIT timeout counter.
module done_tracker #(
  parameter int NUM_NEURONS = 10,
  parameter int WAIT_LIMIT  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   en,
  input  logic [NUM_NEURONS-1:0] neuron_done,
  output logic                   all_done,
  output logic                   timeout
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [NUM_NEURONS-1:0] done_mask;
  logic [NUM_NEURONS-1:0] merged;
  logic [CNT_W-1:0]       wait_cnt;

  // A done arriving in the completing cycle counts, so detect on the merged view.
  assign merged   = done_mask | neuron_done;
  assign all_done = en && (&merged);
  assign timeout  = en && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_mask <= '0;
      wait_cnt  <= '0;
    end else if (clear) begin
      done_mask <= '0;
      wait_cnt  <= '0;
    end else if (en) begin
      done_mask <= merged;
      wait_cnt  <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/layer_input_loader.sv
// Serial-to-parallel frame loader for one neuron layer: fills input_vector, fires start,
// then waits for every neuron's done (or a timeout) before accepting the next frame.
module layer_input_loader
  import dnn_pkg::*;
#(
  parameter int INPUT_SIZE  = 784,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_NEURONS = 10,
  parameter int WAIT_LIMIT  = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  data_t                         pix_data,
  input  logic                          pix_valid,
  input  logic                          pix_last,
  output logic                          pix_ready,
  output data_t [INPUT_SIZE-1:0]        input_vector,
  output logic                          start,
  input  logic [NUM_NEURONS-1:0]        neuron_done,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          err_len,
  output logic                          err_timeout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INPUT_SIZE - 1);

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  beat;
  logic                  all_done;
  logic                  timeout;

  assign pix_ready = (state == LOAD) || (state == DRAIN);
  assign beat      = pix_valid && pix_ready;

  done_tracker #(
    .NUM_NEURONS (NUM_NEURONS),
    .WAIT_LIMIT  (WAIT_LIMIT)
  ) u_done_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (state == FIRE),
    .en          (state == WAIT),
    .neuron_done (neuron_done),
    .all_done    (all_done),
    .timeout     (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      wr_addr      <= '0;
      input_vector <= '0;
      start        <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      start       <= 1'b0;
      frame_done  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        LOAD: begin
          if (beat) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
              if (wr_addr == ADDR_WIDTH'(i)) input_vector[i] <= pix_data;
            end
            if (wr_addr == LAST_ADDR) begin
              wr_addr <= '0;
              if (pix_last) begin
                state <= FIRE;
                start <= 1'b1;
                busy  <= 1'b1;
              end else begin
                // Frame overran the buffer: flag it and discard up to its last beat.
                err_len <= 1'b1;
                state   <= DRAIN;
              end
            end else if (pix_last) begin
              err_len <= 1'b1;
              wr_addr <= '0;
            end else begin
              wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (all_done) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= LOAD;
          end else if (timeout) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= LOAD;
          end
        end
        DRAIN: begin
          if (beat && pix_last) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_input_loader.sv
// Randomized scoreboard bench for layer_input_loader (INPUT_SIZE=4, NUM_NEURONS=3, WAIT_LIMIT=16).
module tb_layer_input_loader;

  localparam int IS = 4;
  localparam int NN = 3;
  localparam int WL = 16;

  localparam int K_START = 0;
  localparam int K_LEN   = 1;
  localparam int K_FDONE = 2;
  localparam int K_TOUT  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] vec;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] pix_data;
  logic               pix_valid;
  logic               pix_last;
  logic               pix_ready;
  logic [63:0]        input_vector;
  logic               start;
  logic [NN-1:0]      neuron_done;
  logic               frame_done;
  logic               busy;
  logic               err_len;
  logic               err_timeout;

  layer_input_loader #(
    .INPUT_SIZE  (IS),
    .ADDR_WIDTH  (2),
    .NUM_NEURONS (NN),
    .WAIT_LIMIT  (WL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .input_vector (input_vector),
    .start        (start),
    .neuron_done  (neuron_done),
    .frame_done   (frame_done),
    .busy         (busy),
    .err_len      (err_len),
    .err_timeout  (err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit suspend = 0;

  // Reference model state
  exp_t          q[$];
  logic [15:0]   mbuf[$];
  logic [15:0]   fv[$];
  bit            in_drain = 0;
  int            busy_from = 0;
  int            busy_until = 0;
  bit [NN-1:0]   sched[int];
  int            off_a[NN];
  int            off_b[NN];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_ready(input int c);
    return !(c >= busy_from && c < busy_until);
  endfunction

  function automatic bit in_win(input int o);
    return (o >= 1) && (o <= WL);
  endfunction

  // Fired frame: neurons count only pulses inside the WAIT window; the frame
  // completes when the slowest neuron's first counted pulse arrives.
  task automatic model_fire();
    logic [63:0] v;
    int s, m, e, endc;
    bit all;
    exp_t x;
    s = cyc + 1;
    v = '0;
    for (int i = 0; i < IS; i++) v[16*i +: 16] = mbuf[i];
    x.kind = K_START; x.cyc = s; x.vec = v;
    q.push_back(x);
    all = 1; m = 0;
    for (int j = 0; j < NN; j++) begin
      e = 1000;
      if (in_win(off_a[j])) e = off_a[j];
      if (in_win(off_b[j]) && off_b[j] < e) e = off_b[j];
      if (e == 1000) all = 0;
      else if (e > m) m = e;
    end
    endc = all ? (s + m + 1) : (s + WL + 1);
    x.kind = all ? K_FDONE : K_TOUT; x.cyc = endc; x.vec = v;
    q.push_back(x);
    busy_from = s;
    busy_until = endc;
    for (int j = 0; j < NN; j++) begin
      if (off_a[j] >= 0 && s + off_a[j] <= endc)
        sched[s + off_a[j]] = (sched.exists(s + off_a[j]) ? sched[s + off_a[j]] : '0) | (NN'(1) << j);
      if (off_b[j] >= 0 && s + off_b[j] <= endc)
        sched[s + off_b[j]] = (sched.exists(s + off_b[j]) ? sched[s + off_b[j]] : '0) | (NN'(1) << j);
    end
  endtask

  task automatic model_beat(input logic [15:0] d, input bit last);
    exp_t x;
    if (in_drain) begin
      if (last) in_drain = 0;
    end else begin
      mbuf.push_back(d);
      if (last) begin
        if (mbuf.size() == IS) model_fire();
        else begin
          x.kind = K_LEN; x.cyc = cyc + 1; x.vec = '0;
          q.push_back(x);
        end
        mbuf.delete();
      end else if (mbuf.size() == IS) begin
        x.kind = K_LEN; x.cyc = cyc + 1; x.vec = '0;
        q.push_back(x);
        in_drain = 1;
        mbuf.delete();
      end
    end
  endtask

  task automatic set_offs(input int a0, input int a1, input int a2);
    off_a[0] = a0; off_a[1] = a1; off_a[2] = a2;
    for (int j = 0; j < NN; j++) off_b[j] = -1;
  endtask

  task automatic rand_offs();
    for (int j = 0; j < NN; j++) begin
      off_a[j] = ($urandom_range(99) < 12) ? -1 : int'($urandom_range(12, 1));
      off_b[j] = ($urandom_range(1) == 1) ? int'($urandom_range((off_a[j] > 0) ? off_a[j] : 12, 0)) : -1;
    end
  endtask

  task automatic make_seq(input int first, input int len);
    fv.delete();
    for (int i = 0; i < len; i++) fv.push_back(16'(first + i));
  endtask

  task automatic send_frame(input int vpct);
    int idx;
    int guard;
    idx = 0; guard = 0;
    while (idx < fv.size()) begin
      @(negedge clk);
      pix_valid = ($urandom_range(99) < vpct);
      pix_data  = fv[idx];
      pix_last  = (idx == fv.size() - 1);
      if (pix_valid && model_ready(cyc)) begin
        model_beat(fv[idx], pix_last);
        idx++;
      end
      guard++;
      if (guard > 2000) begin
        n_tests++; n_fail++;
        $display("FAIL frame_progress: beat %0d of %0d never accepted", idx, fv.size());
        break;
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 300) begin
      idle(1);
      g++;
    end
    n_tests++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected events never seen, required 0", q.size());
      q.delete();
    end
  endtask

  // Neuron done pulses from the schedule.
  initial begin
    neuron_done = '0;
    forever begin
      @(negedge clk);
      neuron_done = (!suspend && sched.exists(cyc)) ? sched[cyc] : '0;
    end
  end

  // Handshake/busy monitor.
  initial forever begin
    @(negedge clk);
    if (!suspend && rst_n) begin
      check("pix_ready", {63'd0, pix_ready}, {63'd0, model_ready(cyc)});
      check("busy", {63'd0, busy}, {63'd0, !model_ready(cyc)});
    end
  end

  // Event scoreboard.
  initial forever begin
    int   gk;
    exp_t e;
    @(negedge clk);
    if (!suspend) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missing_event: kind %0d due at cycle %0d not seen by cycle %0d", e.kind, e.cyc, cyc);
      end
      if (start || err_len || frame_done || err_timeout) begin
        check("single_event", 64'($countones({start, err_len, frame_done, err_timeout})), 64'd1);
        gk = start ? K_START : err_len ? K_LEN : frame_done ? K_FDONE : K_TOUT;
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", gk, cyc);
        end else begin
          e = q.pop_front();
          check("event_kind", 64'(gk), 64'(e.kind));
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind != K_LEN) check("input_vector", input_vector, e.vec);
        end
      end
    end
  end

  initial begin
    int lens[7];
    lens[0] = 2; lens[1] = 3; lens[2] = 4; lens[3] = 4; lens[4] = 4; lens[5] = 5; lens[6] = 6;
    rst_n = 1'b0; pix_valid = 1'b0; pix_last = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    check("rst_start", {63'd0, start}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_err_len", {63'd0, err_len}, 64'd0);
    check("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_vector", input_vector, 64'd0);
    check("rst_pix_ready", {63'd0, pix_ready}, 64'd1);
    rst_n = 1'b1;

    // Nominal frame
    make_seq(1, 4); set_offs(2, 3, 5); send_frame(100);
    // Backpressure, two back-to-back frames
    for (int f = 0; f < 2; f++) begin
      fv.delete();
      for (int i = 0; i < IS; i++) fv.push_back(16'($urandom));
      rand_offs(); send_frame(50);
    end
    // Short frame then good frame
    make_seq(9, 3); send_frame(100);
    make_seq(5, 4); set_offs(1, 2, 3); send_frame(100);
    // Long frame then good frame
    make_seq(20, 6); send_frame(100);
    make_seq(40, 4); set_offs(4, 1, 2); send_frame(100);
    // Timeout: neuron 2 never reports
    make_seq(60, 4); set_offs(3, 4, -1); send_frame(100);
    // Simultaneous done in first WAIT cycle
    make_seq(70, 4); set_offs(1, 1, 1); send_frame(100);
    // Random mix
    for (int f = 0; f < 20; f++) begin
      fv.delete();
      for (int i = 0; i < lens[$urandom_range(6)]; i++) fv.push_back(16'($urandom));
      rand_offs();
      send_frame(int'($urandom_range(100, 30)));
    end
    wait_drain();

    // Reset during WAIT
    make_seq(100, 4); set_offs(-1, -1, -1); send_frame(100);
    idle(6);
    suspend = 1;
    #1 rst_n = 1'b0;
    #1;
    check("arst_start", {63'd0, start}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_frame_done", {63'd0, frame_done}, 64'd0);
    check("arst_err_timeout", {63'd0, err_timeout}, 64'd0);
    check("arst_vector", input_vector, 64'd0);
    check("arst_pix_ready", {63'd0, pix_ready}, 64'd1);
    q.delete(); sched.delete(); mbuf.delete();
    in_drain = 0; busy_from = 0; busy_until = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    suspend = 0;
    #1 check("post_rst_pix_ready", {63'd0, pix_ready}, 64'd1);
    make_seq(200, 4); set_offs(2, 2, 6); send_frame(100);
    wait_drain();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
